// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Address/instruction widths, reset PC, PC step and buffer depth live here.
package if_fetch_pkg;

  localparam int unsigned InstBufDepth = 2;

  typedef logic [31:0] inst_addr_t;
  typedef logic [31:0] inst_t;

  localparam inst_addr_t ZeroWord = 32'h0000_0000;
  localparam inst_addr_t PcStep   = 32'd4;
  localparam inst_addr_t ResetPc  = 32'h0000_0000;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } fetch_entry_t;

  function automatic inst_addr_t word_align(input inst_addr_t a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus: ROM request/response, IF/ID handshake and redirect.
// master = fetch stage, slave = ROM plus downstream pipeline.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic       id_ready;
  logic       flush;
  inst_addr_t new_pc;
  logic       rom_ce;
  inst_addr_t rom_addr;
  inst_t      rom_inst;
  logic       if_valid;
  inst_addr_t if_pc;
  inst_t      if_inst;

  modport master (
    input  id_ready, flush, new_pc, rom_inst,
    output rom_ce, rom_addr, if_valid, if_pc, if_inst
  );

  modport slave (
    output id_ready, flush, new_pc, rom_inst,
    input  rom_ce, rom_addr, if_valid, if_pc, if_inst
  );

endinterface

// File: rtl/if_fetch_buf.sv
// Synchronous {pc,inst} FIFO; push visible at head next cycle, zeroed head when empty.
// No internal backpressure: the caller guarantees it never pushes into a full buffer.
module if_fetch_buf
  import if_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = InstBufDepth,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  inst_addr_t    push_pc,
  input  inst_t         push_inst,
  input  logic          pop,
  output logic          head_valid,
  output inst_addr_t    head_pc,
  output inst_t         head_inst,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    if (push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= '{pc: push_pc, inst: push_inst};
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head_pc    = head_valid ? mem_q[rd_ptr_q].pc   : ZeroWord;
  assign head_inst  = head_valid ? mem_q[rd_ptr_q].inst : ZeroWord;

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, drives the sync ROM, request->head latency 2 cycles.
// id_ready low freezes the head; fetch stops once buffered+in-flight reaches DEPTH.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter inst_addr_t  RESET_PC = ResetPc,
  parameter int unsigned DEPTH    = InstBufDepth
) (
  input logic         clk,
  input logic         rst,
  if_fetch_if.master  bus
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  inst_addr_t    fetch_pc_q, fetch_pc_d;
  inst_addr_t    req_pc_q, req_pc_d;
  logic          inflight_q, inflight_d;

  logic [CW-1:0] count;
  logic          head_valid;
  inst_addr_t    head_pc;
  inst_t         head_inst;
  logic          hold, pop, push, issue;
  logic [CW:0]   occupancy;

  // Reset and redirect both present an empty stage to IF/ID.
  assign hold          = rst | bus.flush;
  assign bus.if_valid  = head_valid & ~hold;
  assign bus.if_pc     = hold ? ZeroWord : head_pc;
  assign bus.if_inst   = hold ? ZeroWord : head_inst;

  assign pop       = bus.if_valid & bus.id_ready;
  assign push      = inflight_q & ~bus.flush;
  assign occupancy = {1'b0, count} - (CW+1)'(pop) + (CW+1)'(inflight_q);
  assign issue     = ~hold & (occupancy < (CW+1)'(DEPTH));

  assign bus.rom_ce   = issue;
  assign bus.rom_addr = fetch_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = issue;
    if (bus.flush) begin
      fetch_pc_d = word_align(bus.new_pc);
    end else if (issue) begin
      fetch_pc_d = fetch_pc_q + PcStep;
      req_pc_d   = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
    end
  end

  // The ROM returns data only, so the entry PC comes from the registered request address.
  if_fetch_buf #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .clr        (bus.flush),
    .push       (push),
    .push_pc    (req_pc_q),
    .push_inst  (bus.rom_inst),
    .pop        (pop),
    .head_valid (head_valid),
    .head_pc    (head_pc),
    .head_inst  (head_inst),
    .count      (count)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Directed and random-stall checks of if_fetch against a word-indexed ROM model.
module tb_if_fetch;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_pc;
  int   accepted = 0;
  logic ovf;

  if_fetch_if bus ();

  if_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a >> 2) * 32'd16 + 32'd1;
  endfunction

  always @(posedge clk) bus.rom_inst <= bus.rom_ce ? rom_word(bus.rom_addr) : 32'h0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'b0, bus.if_valid}, 32'd1);
    chk({tag, "_pc"}, bus.if_pc, pc);
    chk({tag, "_inst"}, bus.if_inst, rom_word(pc));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst          = 1'b1;
    bus.id_ready = 1'b1;
    bus.flush    = 1'b0;
    bus.new_pc   = 32'h0;
    cyc();
    cyc();
    chk("rst_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("rst_pc", bus.if_pc, 32'h0);
    chk("rst_inst", bus.if_inst, 32'h0);
    chk("rst_ce", {31'b0, bus.rom_ce}, 32'd0);

    // 1: release reset, stream from RESET_PC
    cyc(); rst = 1'b0; #1;
    chk("t1_ce0", {31'b0, bus.rom_ce}, 32'd1);
    chk("t1_addr0", bus.rom_addr, 32'h0);
    chk("t1_valid0", {31'b0, bus.if_valid}, 32'd0);
    cyc();
    chk("t1_valid1", {31'b0, bus.if_valid}, 32'd0);
    chk("t1_addr1", bus.rom_addr, 32'h4);
    cyc(); chk_head("t1_c2", 32'h0);
    cyc(); chk_head("t1_c3", 32'h4);
    cyc(); chk_head("t1_c4", 32'h8);
    cyc(); chk_head("t1_c5", 32'hC);

    // 2: stall for 5 cycles, head frozen at 0x10, fetch stops
    for (int i = 0; i < 5; i++) begin
      cyc(); bus.id_ready = 1'b0; #1;
      chk_head("t2_stall", 32'h10);
      chk("t2_ce", {31'b0, bus.rom_ce}, 32'd0);
    end
    cyc(); bus.id_ready = 1'b1; #1;
    chk_head("t2_rel0", 32'h10);
    chk("t2_rel_ce", {31'b0, bus.rom_ce}, 32'd1);
    chk("t2_rel_addr", bus.rom_addr, 32'h18);
    cyc(); chk_head("t2_rel1", 32'h14);
    cyc(); chk_head("t2_rel2", 32'h18);
    cyc(); chk_head("t2_rel3", 32'h1C);

    // 3: flush with head buffered and a response in flight
    cyc(); bus.id_ready = 1'b0; bus.flush = 1'b1; bus.new_pc = 32'h0000_0103; #1;
    chk("t3_F_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("t3_F_ce", {31'b0, bus.rom_ce}, 32'd0);
    cyc(); bus.flush = 1'b0; bus.id_ready = 1'b1; #1;
    chk("t3_F1_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("t3_F1_ce", {31'b0, bus.rom_ce}, 32'd1);
    chk("t3_F1_addr", bus.rom_addr, 32'h100);
    cyc();
    chk("t3_F2_valid", {31'b0, bus.if_valid}, 32'd0);
    cyc(); chk_head("t3_F3", 32'h100);
    cyc(); chk_head("t3_F4", 32'h104);
    cyc(); chk_head("t3_F5", 32'h108);

    // 4: redirect near the top of the address space, PC wraps
    cyc(); bus.flush = 1'b1; bus.new_pc = 32'hFFFF_FFF8; #1;
    chk("t4_G_ce", {31'b0, bus.rom_ce}, 32'd0);
    cyc(); bus.flush = 1'b0; #1;
    chk("t4_G1_addr", bus.rom_addr, 32'hFFFF_FFF8);
    cyc();
    chk("t4_G2_valid", {31'b0, bus.if_valid}, 32'd0);
    cyc(); chk_head("t4_G3", 32'hFFFF_FFF8);
    chk("t4_G3_addr", bus.rom_addr, 32'h0);
    cyc(); chk_head("t4_G4", 32'hFFFF_FFFC);
    cyc(); chk_head("t4_G5", 32'h0);
    cyc(); chk_head("t4_G6", 32'h4);

    // 5: reset mid-stream with a full buffer
    cyc(); bus.id_ready = 1'b0; #1;
    chk_head("t5_fill0", 32'h8);
    cyc(); chk_head("t5_fill1", 32'h8);
    cyc(); rst = 1'b1; #1;
    chk("t5_R_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("t5_R_ce", {31'b0, bus.rom_ce}, 32'd0);
    cyc();
    chk("t5_R1_valid", {31'b0, bus.if_valid}, 32'd0);
    chk("t5_R1_pc", bus.if_pc, 32'h0);
    chk("t5_R1_inst", bus.if_inst, 32'h0);
    chk("t5_R1_ce", {31'b0, bus.rom_ce}, 32'd0);
    cyc(); rst = 1'b0; bus.id_ready = 1'b1; #1;
    chk("t5_R2_ce", {31'b0, bus.rom_ce}, 32'd1);
    chk("t5_R2_addr", bus.rom_addr, 32'h0);
    cyc();
    chk("t5_R3_valid", {31'b0, bus.if_valid}, 32'd0);
    cyc(); chk_head("t5_R4", 32'h0);
    exp_pc = 32'h4;

    // 6: random stalls against the scoreboard
    for (int i = 0; i < 1000; i++) begin
      cyc(); bus.id_ready = 1'($urandom_range(0, 1)); #1;
      if (bus.if_valid && bus.id_ready) begin
        chk("t6_pc", bus.if_pc, exp_pc);
        chk("t6_inst", bus.if_inst, rom_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        accepted++;
      end
      ovf = dut.u_buf.push && !dut.u_buf.pop && (dut.u_buf.count == 2'd2);
      chk("t6_overflow", {31'b0, ovf}, 32'd0);
    end
    chk("t6_progress", {31'b0, (accepted >= 300)}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
Name: if_fetch

Overview:
- Instruction-fetch stage. Owns the PC and drives the synchronous instruction ROM.
- Buffers returned instructions and presents if_pc/if_inst with a valid/ready handshake to the IF/ID pipeline register.
- Supports downstream back-pressure (stall) and a branch/exception redirect that flushes everything in flight.
- Sits between inst_rom and if_id.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- DEPTH, 2: instruction buffer entries. Must be at least 2; 2 is required for 1 instr/cycle throughput.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset (`RstEnable = 1'b1).
- id_ready  in  1  IF/ID accepts the current head this cycle (low = stall).
- flush  in  1  redirect request; higher priority than everything except rst.
- new_pc  in  `InstAddrBus  redirect target; bits [1:0] are ignored (forced 0).
- rom_ce  out  1  ROM read enable (combinational from state).
- rom_addr  out  `InstAddrBus  ROM word-aligned byte address (= fetch_pc register).
- rom_inst  in  `InstBus  ROM read data; valid in cycle t+1 for a request with rom_ce=1 in cycle t.
- if_valid  out  1  buffer head valid.
- if_pc  out  `InstAddrBus  PC of head entry; `ZeroWord when empty.
- if_inst  out  `InstBus  instruction of head entry; `ZeroWord when empty.

Behaviour:
- Reset (rst=1 at posedge):
  - fetch_pc <= RESET_PC; buffer cleared (count=0); inflight <= 0.
  - Outputs while in reset: rom_ce=0, if_valid=0, if_pc=if_inst=`ZeroWord.
  - Reset mid-operation discards buffered entries and any in-flight response.
- pop = if_valid & id_ready & ~flush.
- issue (= rom_ce) = ~rst & ~flush & ((count - pop + inflight) < DEPTH).
- On issue: fetch_pc <= fetch_pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0). Set inflight <= 1; otherwise inflight <= 0.
- Response: if inflight=1 and flush=0, the push of {rom_addr_prev, rom_inst} into the buffer tail happens at the end of this cycle.
  - Latency: ROM request in cycle t -> entry visible at buffer head in cycle t+2.
- Push and pop in the same cycle: both take effect; count unchanged. Push into a full buffer cannot occur by construction. Assert this in the bench.
- Flush in cycle F:
  - Buffer cleared, inflight <= 0, fetch_pc <= {new_pc[31:2],2'b00}, rom_ce=0.
  - Any response arriving in F is dropped. No pop occurs in F.
  - First request to new_pc in F+1; if_valid=1 with if_pc=new_pc in F+3.
- flush together with rst: rst wins.
- Throughput: with id_ready held 1, steady state delivers one instruction per cycle with consecutive PCs.
- Stall: id_ready=0 keeps the head stable (if_pc/if_inst/if_valid unchanged). Fetching stops once count+inflight reaches DEPTH.
- Ordering: strictly in PC order between flushes; no duplicates or skips.
- ROM returns data only; the PC of each entry is captured from a registered copy of rom_addr.

Decomposition:
- defines.v gains:
  - `InstBufDepth (2)
  - `PcStep (32'd4)
  - `ResetPc (32'h0000_0000)
- Reuses `InstAddrBus, `InstBus, `ZeroWord, `RstEnable.
- Sub-module if_buf: synchronous FIFO of {pc,inst}.
  - Ports: clk, rst, clr, push, push_pc, push_inst, pop, head_valid, head_pc, head_inst, count.
  - Zeroed head when empty.
- if_fetch holds fetch_pc, inflight, issue logic and flush control.

Test Plan:
1. Reset then id_ready=1, ROM[i]=i*16+1. Expected: rom_ce rises the cycle after rst drops; if_valid rises 2 cycles later with if_pc=0, if_inst=1; following cycles show PCs 4, 8, 12 back-to-back.
2. Stream running, id_ready=0 for 5 cycles. Expected: head frozen at same PC; rom_ce=0 after count+inflight=2. On release, PCs continue with no gap, duplicate or skip.
3. flush=1, new_pc=32'h0000_0103, while buffer full and a request is in flight. Expected: if_valid=0 for cycles F..F+2; rom_addr=32'h100 at F+1; if_pc=32'h100 at F+3; no old PC ever appears after F.
4. Wrap: new_pc=32'hFFFF_FFF8 via flush, id_ready=1. Expected: PCs FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
5. rst asserted mid-stream with a full buffer. Expected: next cycle if_valid=0, if_pc=if_inst=0, rom_ce=0; restart from RESET_PC.
6. Random id_ready (50%) over 1000 cycles versus a scoreboard. Expected: accepted PCs strictly +4 sequential; if_inst matches the ROM model; buffer never overflows.
